// File: rtl/full_adder.sv
// Ripple-carry adder built from one-bit full-adder cells, with a combinational
// result and a one-cycle registered copy (sum, carry, signed overflow, valid).
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             en,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             valid_q
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;

  assign w_c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign w_s[i]   = in1[i] ^ in2[i] ^ w_c[i];
    assign w_c[i+1] = (in1[i] & in2[i]) | (in1[i] & w_c[i]) | (in2[i] & w_c[i]);
  end

  // Overflow compares the carry into and out of the sign bit; for WIDTH=1
  // the carry into the sign bit is cin itself.
  assign sum  = w_s;
  assign cout = w_c[WIDTH];
  assign ovf  = w_c[WIDTH] ^ w_c[WIDTH-1];

  logic [WIDTH-1:0] r_sum_p1;
  logic             r_cout_p1;
  logic             r_ovf_p1;
  logic             r_vld_p1;

  // Stage p0 -> p1: capture the combinational result when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum_p1  <= '0;
      r_cout_p1 <= 1'b0;
      r_ovf_p1  <= 1'b0;
      r_vld_p1  <= 1'b0;
    end else if (en) begin
      r_sum_p1  <= w_s;
      r_cout_p1 <= w_c[WIDTH];
      r_ovf_p1  <= w_c[WIDTH] ^ w_c[WIDTH-1];
      r_vld_p1  <= 1'b1;
    end
  end

  assign sum_q   = r_sum_p1;
  assign cout_q  = r_cout_p1;
  assign ovf_q   = r_ovf_p1;
  assign valid_q = r_vld_p1;

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: a 1-bit and an 8-bit instance checked against an
// integer-arithmetic reference model, directed cases plus random vectors.
module tb_full_adder;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, en1, ci1;
  logic [0:0] a1, b1, s1, sq1;
  logic       co1, ov1, cq1, oq1, vq1;

  logic       rst8, en8, ci8;
  logic [7:0] a8, b8, s8, sq8;
  logic       co8, ov8, cq8, oq8, vq8;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] e8_sq; logic e8_cq, e8_oq, e8_vq;
  logic [0:0] e1_sq; logic e1_cq, e1_oq, e1_vq;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst1), .in1(a1), .in2(b1), .cin(ci1), .en(en1),
    .sum(s1), .cout(co1), .ovf(ov1),
    .sum_q(sq1), .cout_q(cq1), .ovf_q(oq1), .valid_q(vq1)
  );

  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst8), .in1(a8), .in2(b8), .cin(ci8), .en(en8),
    .sum(s8), .cout(co8), .ovf(ov8),
    .sum_q(sq8), .cout_q(cq8), .ovf_q(oq8), .valid_q(vq8)
  );

  function automatic void ref8(input logic [7:0] a, input logic [7:0] b, input logic c,
                               output logic [7:0] s, output logic co, output logic ov);
    int u, sv;
    u  = int'(a) + int'(b) + int'(c);
    sv = int'($signed(a)) + int'($signed(b)) + int'(c);
    s  = u[7:0];
    co = (u > 255);
    ov = (sv > 127) || (sv < -128);
  endfunction

  function automatic void ref1(input logic [0:0] a, input logic [0:0] b, input logic c,
                               output logic [0:0] s, output logic co, output logic ov);
    int u, sv;
    u  = int'(a) + int'(b) + int'(c);
    sv = int'($signed(a)) + int'($signed(b)) + int'(c);
    s  = u[0:0];
    co = (u > 1);
    ov = (sv > 0) || (sv < -1);
  endfunction

  task automatic test_reset();
    rst1 = 1'b1; en1 = 1'b1; a1 = 1'b1; b1 = 1'b0; ci1 = 1'b1;
    rst8 = 1'b1; en8 = 1'b1; a8 = 8'h5A; b8 = 8'hC3; ci8 = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({sq1, cq1, oq1, vq1} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_w1: got %b required 0000", {sq1, cq1, oq1, vq1});
    end
    n_vec++;
    if ({sq8, cq8, oq8, vq8} !== 11'b0) begin
      n_err++;
      $display("FAIL reset_w8: got %h/%b%b%b required 00/000", sq8, cq8, oq8, vq8);
    end
  endtask

  task automatic test_rst_hold_w1();
    @(negedge clk);
    rst1 = 1'b1; en1 = 1'b1; a1 = 1'b1; b1 = 1'b1; ci1 = 1'b0;
    #1;
    n_vec++;
    if ({co1, s1} !== 2'b10) begin
      n_err++;
      $display("FAIL rst_comb_w1: got {cout,sum}=%b%b required 10", co1, s1);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({sq1, cq1, oq1, vq1} !== 4'b0) begin
        n_err++;
        $display("FAIL rst_hold_w1[%0d]: got %b required 0000", k, {sq1, cq1, oq1, vq1});
      end
    end
    @(negedge clk);
    rst1 = 1'b0;
  endtask

  task automatic test_truth_table();
    logic [1:0] req [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    logic [2:0] v;
    logic [0:0] es; logic eco, eov;
    en1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; ci1 = v[0];
      #1;
      ref1(a1, b1, ci1, es, eco, eov);
      n_vec++;
      if ({co1, s1, ov1} !== {req[i], eov}) begin
        n_err++;
        $display("FAIL truth_table[%b]: got {cout,sum,ovf}=%b%b%b required %b%b", v, co1, s1, ov1, req[i], eov);
      end
    end
  endtask

  task automatic test_w8_carry();
    @(negedge clk);
    rst8 = 1'b0; en8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0;
    #1;
    n_vec++;
    if ({co8, s8, ov8} !== {1'b1, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL carry_comb: got sum=%h cout=%b ovf=%b required 00/1/0", s8, co8, ov8);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({sq8, cq8, oq8, vq8} !== {8'h00, 1'b1, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL carry_reg: got sum_q=%h cout_q=%b ovf_q=%b valid_q=%b required 00/1/0/1", sq8, cq8, oq8, vq8);
    end
  endtask

  task automatic test_w8_overflow();
    @(negedge clk);
    en8 = 1'b0; a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b0;
    #1;
    n_vec++;
    if ({co8, s8, ov8} !== {1'b0, 8'h80, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_pos: got sum=%h cout=%b ovf=%b required 80/0/1", s8, co8, ov8);
    end
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0;
    #1;
    n_vec++;
    if ({co8, s8, ov8} !== {1'b1, 8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_neg: got sum=%h cout=%b ovf=%b required 00/1/1", s8, co8, ov8);
    end
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    #1;
    n_vec++;
    if ({co8, s8, ov8} !== {1'b1, 8'hFF, 1'b0}) begin
      n_err++;
      $display("FAIL all_ones: got sum=%h cout=%b ovf=%b required FF/1/0", s8, co8, ov8);
    end
    @(negedge clk);
    a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0;
    #1;
    n_vec++;
    if ({co8, s8, ov8} !== 10'b0) begin
      n_err++;
      $display("FAIL all_zeros: got sum=%h cout=%b ovf=%b required 00/0/0", s8, co8, ov8);
    end
  endtask

  task automatic test_enable_hold();
    @(negedge clk);
    en8 = 1'b1; a8 = 8'h12; b8 = 8'h34; ci8 = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({sq8, cq8, vq8} !== {8'h47, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL en_capture: got sum_q=%h cout_q=%b valid_q=%b required 47/0/1", sq8, cq8, vq8);
    end
    @(negedge clk);
    en8 = 1'b0; a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b1;
    #1;
    n_vec++;
    if ({co8, s8} !== {1'b1, 8'h00}) begin
      n_err++;
      $display("FAIL hold_comb: got sum=%h cout=%b required 00/1", s8, co8);
    end
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({sq8, cq8, oq8, vq8} !== {8'h47, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL en_hold: got sum_q=%h cout_q=%b ovf_q=%b valid_q=%b required 47/0/0/1", sq8, cq8, oq8, vq8);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] es; logic eco, eov;
    @(negedge clk);
    rst8 = 1'b1; en8 = 1'b1; a8 = 8'h7F; b8 = 8'h7F; ci8 = 1'b1;
    #1;
    ref8(a8, b8, ci8, es, eco, eov);
    n_vec++;
    if ({co8, s8, ov8} !== {eco, es, eov}) begin
      n_err++;
      $display("FAIL rst_comb_w8: got %b%h%b required %b%h%b", co8, s8, ov8, eco, es, eov);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({sq8, cq8, oq8, vq8} !== 11'b0) begin
      n_err++;
      $display("FAIL rst_mid: got sum_q=%h %b%b%b required 00 000", sq8, cq8, oq8, vq8);
    end
    @(negedge clk);
    rst8 = 1'b0; a8 = 8'h90; b8 = 8'hA5; ci8 = 1'b0;
    ref8(a8, b8, ci8, es, eco, eov);
    @(posedge clk); #1;
    n_vec++;
    if ({sq8, cq8, oq8, vq8} !== {es, eco, eov, 1'b1}) begin
      n_err++;
      $display("FAIL rst_reload: got %h%b%b%b required %h%b%b1", sq8, cq8, oq8, vq8, es, eco, eov);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] es; logic eco, eov;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      en8 = 1'b1; rst8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      ref8(a8, b8, ci8, es, eco, eov);
      @(posedge clk); #1;
      n_vec++;
      if ({sq8, cq8, oq8, vq8} !== {es, eco, eov, 1'b1}) begin
        n_err++;
        $display("FAIL b2b[%0d]: got %h%b%b%b required %h%b%b1", k, sq8, cq8, oq8, vq8, es, eco, eov);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] es8; logic eco8, eov8;
    logic [0:0] es1; logic eco1, eov1;
    @(negedge clk);
    rst1 = 1'b1; rst8 = 1'b1;
    @(posedge clk);
    e8_sq = '0; e8_cq = 1'b0; e8_oq = 1'b0; e8_vq = 1'b0;
    e1_sq = '0; e1_cq = 1'b0; e1_oq = 1'b0; e1_vq = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      rst8 = ($urandom_range(15) == 0); en8 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      rst1 = ($urandom_range(15) == 0); en1 = 1'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
      #1;
      ref8(a8, b8, ci8, es8, eco8, eov8);
      ref1(a1, b1, ci1, es1, eco1, eov1);
      n_vec++;
      if ({co8, s8, ov8} !== {eco8, es8, eov8}) begin
        n_err++;
        $display("FAIL rand_comb_w8[%0d]: %h+%h+%b got %b%h%b required %b%h%b", k, a8, b8, ci8, co8, s8, ov8, eco8, es8, eov8);
      end
      n_vec++;
      if ({co1, s1, ov1} !== {eco1, es1, eov1}) begin
        n_err++;
        $display("FAIL rand_comb_w1[%0d]: %b+%b+%b got %b%b%b required %b%b%b", k, a1, b1, ci1, co1, s1, ov1, eco1, es1, eov1);
      end
      if (rst8) begin
        e8_sq = '0; e8_cq = 1'b0; e8_oq = 1'b0; e8_vq = 1'b0;
      end else if (en8) begin
        e8_sq = es8; e8_cq = eco8; e8_oq = eov8; e8_vq = 1'b1;
      end
      if (rst1) begin
        e1_sq = '0; e1_cq = 1'b0; e1_oq = 1'b0; e1_vq = 1'b0;
      end else if (en1) begin
        e1_sq = es1; e1_cq = eco1; e1_oq = eov1; e1_vq = 1'b1;
      end
      @(posedge clk); #1;
      n_vec++;
      if ({sq8, cq8, oq8, vq8} !== {e8_sq, e8_cq, e8_oq, e8_vq}) begin
        n_err++;
        $display("FAIL rand_reg_w8[%0d]: got %h%b%b%b required %h%b%b%b", k, sq8, cq8, oq8, vq8, e8_sq, e8_cq, e8_oq, e8_vq);
      end
      n_vec++;
      if ({sq1, cq1, oq1, vq1} !== {e1_sq, e1_cq, e1_oq, e1_vq}) begin
        n_err++;
        $display("FAIL rand_reg_w1[%0d]: got %b%b%b%b required %b%b%b%b", k, sq1, cq1, oq1, vq1, e1_sq, e1_cq, e1_oq, e1_vq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rst_hold_w1();
    test_truth_table();
    test_w8_carry();
    test_w8_overflow();
    test_enable_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
